// File: rtl/sar_pkg.sv
`default_nettype none
//=== sar_pkg -- shared FSM state type, encodings and width helper ===
//=== rev 1.0 ===
package sar_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ENC_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ENC_SAMPLE  = 2'd1;
  localparam logic [STATE_W-1:0] ENC_CONVERT = 2'd2;
  localparam logic [STATE_W-1:0] ENC_DONE    = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = ENC_IDLE,
    ST_SAMPLE  = ENC_SAMPLE,
    ST_CONVERT = ENC_CONVERT,
    ST_DONE    = ENC_DONE
  } sar_state_e;

  // Bits needed to index n items, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_bit_engine.sv
`default_nettype none
//=== sar_bit_engine -- successive-approximation trial register and bit index ===
//=== rev 1.0 ===
module sar_bit_engine
  import sar_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             comp,
  output logic [WIDTH-1:0] code,
  output logic [WIDTH-1:0] next_code,
  output logic             last
);

  localparam int              IW       = clog2(WIDTH);
  localparam logic [IW-1:0]   IDX_MSB  = IW'(WIDTH - 1);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [WIDTH-1:0] CODE_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  logic [IW-1:0] idx;

  // Resolve the current bit from the comparator and arm the next lower trial bit.
  always_comb begin
    next_code      = code;
    next_code[idx] = comp;
    if (idx != '0) next_code[idx - IDX_ONE] = 1'b1;
  end

  assign last = (idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= '0;
      idx  <= '0;
    end else if (load) begin
      code <= CODE_MSB;
      idx  <= IDX_MSB;
    end else if (step) begin
      code <= next_code;
      if (!last) idx <= idx - IDX_ONE;
    end else begin
      code <= '0;
      idx  <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sar_scan_ctrl.sv
`default_nettype none
//=== sar_scan_ctrl -- SAR conversion sequencer with channel scan and continuous mode ===
//=== rev 1.0 ===
module sar_scan_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NCH           = 4,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   cont,
  input  logic                   scan,
  input  logic [clog2(NCH)-1:0]  ch_sel_in,
  input  logic                   abort,
  input  logic                   comp,
  output logic [WIDTH-1:0]       dac_code,
  output logic                   sample,
  output logic [clog2(NCH)-1:0]  ch_sel,
  output logic                   busy,
  output logic [WIDTH-1:0]       result,
  output logic [clog2(NCH)-1:0]  result_ch,
  output logic                   done
);

  localparam int               CHW       = clog2(NCH);
  localparam logic [CHW-1:0]   CH_LAST   = CHW'(NCH - 1);
  localparam logic [CHW-1:0]   CH_ONE    = CHW'(1);
  localparam logic [3:0]       SAMP_LAST = 4'(SAMPLE_CYCLES - 1);

  sar_state_e       state, state_d;
  logic [3:0]       samp_cnt;
  logic [CHW-1:0]   ch_next;
  logic             eng_load, eng_step, eng_last;
  logic [WIDTH-1:0] eng_code, eng_next;

  sar_bit_engine #(.WIDTH(WIDTH)) u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (eng_load),
    .step      (eng_step),
    .comp      (comp),
    .code      (eng_code),
    .next_code (eng_next),
    .last      (eng_last)
  );

  always_comb begin
    state_d  = state;
    busy     = 1'b0;
    sample   = 1'b0;
    done     = 1'b0;
    eng_load = 1'b0;
    eng_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        busy   = 1'b1;
        sample = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (samp_cnt == SAMP_LAST) begin
          state_d  = ST_CONVERT;
          eng_load = 1'b1;
        end
      end
      ST_CONVERT: begin
        busy = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          eng_step = 1'b1;
          if (eng_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = (cont && !abort) ? ST_SAMPLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ch_next  = (ch_sel == CH_LAST) ? '0 : ch_sel + CH_ONE;
  // Trial register is cleared outside CONVERT, so this is zero in IDLE and SAMPLE.
  assign dac_code = eng_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      samp_cnt  <= '0;
      ch_sel    <= '0;
      result    <= '0;
      result_ch <= '0;
    end else begin
      state    <= state_d;
      samp_cnt <= (state == ST_SAMPLE && state_d == ST_SAMPLE) ? samp_cnt + 4'd1 : 4'd0;
      if (state == ST_IDLE && state_d == ST_SAMPLE) begin
        ch_sel <= ch_sel_in;
      end else if (state == ST_DONE && scan) begin
        ch_sel <= ch_next;
      end
      if (state == ST_CONVERT && state_d == ST_DONE) begin
        result    <= eng_next;
        result_ch <= ch_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sar_scan_ctrl.sv
`default_nettype none
//=== tb_sar_scan_ctrl -- directed self-checking bench for sar_scan_ctrl ===
//=== rev 1.0 ===
module tb_sar_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, cont = 1'b0, scan = 1'b0, abort = 1'b0;
  logic [1:0] ch_sel_in = 2'd0;
  logic [1:0] mode = 2'd0;  // 0: comparator model, 1: held high, 2: held low

  logic        comp8, sample8, busy8, done8;
  logic [7:0]  dac8, result8;
  logic [1:0]  ch_sel8, result_ch8;
  logic        comp12, sample12, busy12, done12, ch_sel12, result_ch12;
  logic [11:0] dac12, result12;
  logic        ch_in12 = 1'b0;

  logic [7:0]  chan_vin [4];
  logic [11:0] vin12 = 12'hA5C;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign comp8  = (mode == 2'd0) ? (chan_vin[ch_sel8] >= dac8) : (mode == 2'd1);
  assign comp12 = (vin12 >= dac12);

  sar_scan_ctrl #(.WIDTH(8), .NCH(4), .SAMPLE_CYCLES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .scan(scan),
    .ch_sel_in(ch_sel_in), .abort(abort), .comp(comp8), .dac_code(dac8),
    .sample(sample8), .ch_sel(ch_sel8), .busy(busy8), .result(result8),
    .result_ch(result_ch8), .done(done8)
  );

  sar_scan_ctrl #(.WIDTH(12), .NCH(1), .SAMPLE_CYCLES(1)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .scan(scan),
    .ch_sel_in(ch_in12), .abort(abort), .comp(comp12), .dac_code(dac12),
    .sample(sample12), .ch_sel(ch_sel12), .busy(busy12), .result(result12),
    .result_ch(result_ch12), .done(done12)
  );

  typedef struct {
    logic [7:0] vin;
    logic [1:0] ch;
    logic [1:0] mode;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns the number of rising edges until done, counting the start edge.
  task automatic conv(input bit do_start, input bit sel12, output int n);
    n = 0;
    start = do_start;
    do begin
      tick();
      start = 1'b0;
      n++;
    end while (!(sel12 ? done12 : done8) && n < 60);
  endtask

  initial begin
    int         n;
    int         ndone;
    logic [7:0] e;
    logic [7:0] cont_exp [3];

    vecs[0] = '{8'h5A, 2'd2, 2'd0, 8'h5A};
    vecs[1] = '{8'hFF, 2'd0, 2'd1, 8'hFF};
    vecs[2] = '{8'h00, 2'd1, 2'd2, 8'h00};
    vecs[3] = '{8'h01, 2'd3, 2'd0, 8'h01};
    vecs[4] = '{8'h80, 2'd1, 2'd0, 8'h80};
    vecs[5] = '{8'h7F, 2'd0, 2'd0, 8'h7F};
    cont_exp = '{8'h10, 8'h20, 8'h30};
    for (int i = 0; i < 4; i++) chan_vin[i] = 8'h00;

    // Reset values
    #2;
    chk("rst_dac", 32'(dac8), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_sample", 32'(sample8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_result", 32'(result8), 0);
    chk("rst_ch_sel", 32'(ch_sel8), 0);
    tick();
    rst_n = 1'b1;

    // Single conversions, the first one on the first edge after release
    for (int i = 0; i < 6; i++) begin
      chan_vin[vecs[i].ch] = vecs[i].vin;
      mode      = vecs[i].mode;
      ch_sel_in = vecs[i].ch;
      conv(1'b1, 1'b0, n);
      chk("vec_latency", 32'(n), 11);
      chk("vec_result", 32'(result8), 32'(vecs[i].exp_res));
      chk("vec_result_ch", 32'(result_ch8), 32'(vecs[i].ch));
      tick();
      chk("vec_idle_busy", 32'(busy8), 0);
      chk("vec_idle_done", 32'(done8), 0);
      chk("vec_hold_ch", 32'(ch_sel8), 32'(vecs[i].ch));
    end

    // Trial code sequences with comparator held high then low
    for (int m = 1; m <= 2; m++) begin
      mode  = 2'(m);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("seq_sample", 32'(sample8), 1);
      chk("seq_sample_dac", 32'(dac8), 0);
      tick();
      tick();
      for (int j = 0; j < 8; j++) begin
        if (m == 1) begin
          e = 8'hFF;
          e = e << (7 - j);
        end else begin
          e = 8'h80;
          e = e >> j;
        end
        chk("seq_dac", 32'(dac8), 32'(e));
        tick();
      end
      chk("seq_done", 32'(done8), 1);
      chk("seq_result", 32'(result8), (m == 1) ? 32'hFF : 32'h00);
      tick();
    end

    // Continuous scan from channel 3 with wrap
    chan_vin[0] = 8'h10; chan_vin[1] = 8'h20; chan_vin[2] = 8'h30; chan_vin[3] = 8'h40;
    mode = 2'd0; scan = 1'b1; cont = 1'b1; ch_sel_in = 2'd3;
    conv(1'b1, 1'b0, n);
    chk("cont_latency", 32'(n), 11);
    chk("cont_ch", 32'(result_ch8), 3);
    chk("cont_result", 32'(result8), 32'h40);
    for (int k = 0; k < 3; k++) begin
      conv(1'b0, 1'b0, n);
      chk("cont_period", 32'(n), 11);
      chk("cont_ch", 32'(result_ch8), 32'(k));
      chk("cont_result", 32'(result8), 32'(cont_exp[k]));
    end
    cont = 1'b0;
    tick();
    chk("cont_stop_busy", 32'(busy8), 0);
    chk("cont_stop_ch", 32'(ch_sel8), 3);

    // Abort during the fourth CONVERT clock
    scan = 1'b0; chan_vin[1] = 8'h77; ch_sel_in = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("abort_pre_dac", 32'(dac8), 32'h70);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_dac", 32'(dac8), 0);
    chk("abort_result", 32'(result8), 32'h30);
    chk("abort_result_ch", 32'(result_ch8), 2);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done8) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 0);

    // Start together with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy8), 0);
    repeat (20) tick();

    // Asynchronous reset in the middle of a conversion
    chan_vin[0] = 8'h5A; ch_sel_in = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid_busy", 32'(busy8), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_dac", 32'(dac8), 0);
    chk("arst_busy", 32'(busy8), 0);
    chk("arst_result", 32'(result8), 0);
    chk("arst_result_ch", 32'(result_ch8), 0);
    chk("arst_done", 32'(done8), 0);
    tick();
    rst_n = 1'b1;
    chk("post_rst_result", 32'(result8), 0);
    conv(1'b1, 1'b0, n);
    chk("post_rst_latency", 32'(n), 11);
    chk("post_rst_result", 32'(result8), 32'h5A);
    repeat (20) tick();

    // 12-bit instance, one sample clock, single channel
    scan = 1'b1;
    conv(1'b1, 1'b1, n);
    chk("w12_latency", 32'(n), 14);
    chk("w12_result", 32'(result12), 32'hA5C);
    chk("w12_result_ch", 32'(result_ch12), 0);
    tick();
    chk("w12_ch_hold", 32'(ch_sel12), 0);
    chk("w12_idle", 32'(busy12), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
